median_delay_line: RTL and testbench
====================================

Name: median_delay_line

Overview:
- Parametrised, clock-enabled delay line for the median-filter datapath.
- Delays an N-bit sample stream by DEPTH accepted samples (ce-qualified), not by DEPTH clocks.
- Circular buffer plus an output register. Tracks fill level and flags when the output holds genuine data.
- Sits between the pixel/sample source and the median window logic to align rows or taps. DEPTH=1 degenerates to a single enabled register.

Parameters:
- N, 5: sample width in bits, ≥1.
- DEPTH, 4: delay in accepted samples, ≥1. The buffer holds DEPTH-1 entries; the output register is the last stage.
- CW, $clog2(DEPTH+1): width of the fill counter. Derived localparam; not to be overridden.

Ports:
- clk: input, 1. Single clock; all state updates on the rising edge.
- rst: input, 1. Synchronous, active-high reset.
- ce: input, 1. Sample enable; one sample accepted per clk with ce=1.
- d: input, N. Input sample, sampled when ce=1.
- q: output, N. Delayed sample, registered.
- q_valid: output, 1. High when q holds a real sample, i.e. DEPTH samples accepted since reset or clear.
- fill: output, CW. Samples accepted since reset or clear, saturating at DEPTH.

Behaviour:
- Reset (rst=1 at clk edge): q=0, q_valid=0, fill=0, write pointer=0. rst has priority over ce.
  - Buffer RAM is not reset, so it can infer as distributed/block RAM. Contents after reset are don't-care.
- ce=0: all state holds (q, q_valid, fill, pointer, RAM unchanged).
- Latency: let s_k be the k-th sample accepted after reset (k=1,2,…). After the edge accepting s_k, q = s_(k-DEPTH+1) for k ≥ DEPTH.
  - q is a don't-care for 1 ≤ k < DEPTH and must not be checked while q_valid=0, except right after reset, when it is 0.
- DEPTH=1: no RAM. q <= d on every ce edge; fill goes 0→1 on the first ce; q_valid rises with that same edge.
- DEPTH>1, on each ce edge:
  - rd = mem[ptr], read asynchronously or pre-fetched so that q <= old mem[ptr].
  - mem[ptr] <= d.
  - ptr <= (ptr==DEPTH-2) ? 0 : ptr+1.
  - Read-before-write on the same address is mandatory.
- fill: increments on each ce edge while fill<DEPTH, then saturates. q_valid = (fill==DEPTH), registered in step with fill.
- Pointer wrap: must wrap at DEPTH-2, which need not be a power of two (e.g. DEPTH=5 → ptr sequence 0,1,2,3,0…).
- No back-pressure; ce is the only flow control. q_valid stays high indefinitely once set, until rst or clr.
- Simultaneous rst and ce: reset wins and the sample is discarded.

Optional Feature:
- Macro: MEDIAN_DELAY_LINE_CLR_EN.
- Defined:
  - Adds input clr (1 bit), a synchronous frame/row restart.
  - On a clr edge: fill=0, q_valid=0, ptr=0; q and RAM are unchanged.
  - If ce=1 in the same cycle, the sample is taken as s_1 of the new run: fill=1, mem[0]=d; for DEPTH=1, q=d and q_valid=1.
  - rst has priority over clr.
- Not defined: no clr port; the behaviour above applies unchanged.

Decomposition:
- Package median_pkg: default sample width (5), default delay depth, and a clog2-based width function or constant used for CW and the pointer width, shared with the median window/sort blocks.
- One sub-module, median_delay_ram: parametrised (N, DEPTH-1) single-clock RAM, write-enabled by ce, read-before-write, no reset. Instantiated only under a generate for DEPTH>1.

Test Plan:
- Fill and latency (N=5, DEPTH=4, ce=1 continuously, d=1,2,3,…) → fill=1,2,3,4 on edges 1–4; q_valid rises on edge 4 with q=1; edge 5 gives q=2; edge 10 gives q=7.
- Gapped enable (DEPTH=4, ce pattern 1,0,0,1,1,0,1, d=10,99,99,11,12,99,13) → only accepted samples count; after the 4th accepted (13) q=10, q_valid=1; q and fill hold during ce=0.
- Non-power-of-two wrap (DEPTH=5, 20 consecutive samples d=0..19) → for k ≥ 5, q = d-4 at every edge; no glitch at pointer wrap (ptr 3→0).
- Mid-run reset (DEPTH=4, 6 samples in, then rst=1 with ce=1, d=31) → next cycle q=0, q_valid=0, fill=0; the following samples 7,8,9,10 give q_valid=1, q=7 on the 4th.
- DEPTH=1 (d=5'h1F with ce=1, then ce=0 with d=0) → q=1F, q_valid=1, fill=1 after the first edge; holds 1F while ce=0.
- With MEDIAN_DELAY_LINE_CLR_EN (DEPTH=4, 6 samples, then clr=1 and ce=1 with d=20) → fill=1, q_valid=0, q unchanged; after samples 21,22,23 q=20 and q_valid=1.

Source files
------------

// File: rtl/median_pkg.sv
// Shared constants and width helpers for the median-filter datapath
// (delay line, window and sort blocks).
package median_pkg;

  localparam int MEDIAN_N     = 5;
  localparam int MEDIAN_DEPTH = 4;

  // Address width able to index `count` entries; never narrower than one bit.
  function automatic int width_of(input int count);
    return (count <= 1) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/median_delay_ram.sv
// Single-clock storage for the delay line: asynchronous read, write on we,
// so a read and write to the same address in one cycle returns the old word.
module median_delay_ram
  import median_pkg::*;
#(
  parameter  int N     = MEDIAN_N,
  parameter  int WORDS = MEDIAN_DEPTH - 1,
  localparam int AW    = width_of(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [N-1:0]  wdata,
  output logic [N-1:0]  rdata
);

  logic [N-1:0] r_mem [WORDS];

  assign rdata = r_mem[addr];

  // NOTE: storage deliberately has no reset so it can map onto LUT/block RAM.
  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= wdata;
  end

endmodule

// File: rtl/median_delay_line.sv
// Clock-enabled delay line: q follows d by DEPTH accepted samples.
// Define MEDIAN_DELAY_LINE_CLR_EN to add the synchronous clr restart input.
module median_delay_line
  import median_pkg::*;
#(
  parameter  int N     = MEDIAN_N,
  parameter  int DEPTH = MEDIAN_DEPTH,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
`ifdef MEDIAN_DELAY_LINE_CLR_EN
  input  logic          clr,
`endif
  input  logic          ce,
  input  logic [N-1:0]  d,
  output logic [N-1:0]  q,
  output logic          q_valid,
  output logic [CW-1:0] fill
);

  logic          w_clr;
  logic [N-1:0]  r_q;
  logic          r_valid;
  logic [CW-1:0] r_fill;
  logic [CW-1:0] w_fill_nxt;

`ifdef MEDIAN_DELAY_LINE_CLR_EN
  assign w_clr = clr;
`else
  assign w_clr = 1'b0;
`endif

  // A clr that coincides with ce counts that sample as the first of the new run.
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
    w_fill_nxt = r_fill;
    if (w_clr)
      w_fill_nxt = ce ? CW'(1) : '0;
    else if (ce && r_fill != CW'(DEPTH))
      w_fill_nxt = r_fill + 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      r_fill  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_fill  <= w_fill_nxt;
      r_valid <= (w_fill_nxt == CW'(DEPTH));
    end
  end

  generate
    if (DEPTH == 1) begin : g_reg
      always_ff @(posedge clk) begin
        if (rst)     r_q <= '0;
        else if (ce) r_q <= d;
      end
    end else begin : g_ram
      localparam int AW = width_of(DEPTH - 1);

      logic [AW-1:0] r_ptr;
      logic [AW-1:0] w_addr;
      logic [N-1:0]  w_rd;

      // A restart rewinds to slot 0 in the same cycle a sample may be written.
      assign w_addr = w_clr ? '0 : r_ptr;

      median_delay_ram #(
        .N     (N),
        .WORDS (DEPTH - 1)
      ) u_ram (
        .clk   (clk),
        .we    (ce),
        .addr  (w_addr),
        .wdata (d),
        .rdata (w_rd)
      );

      always_ff @(posedge clk) begin
        if (rst) begin
          r_ptr <= '0;
          r_q   <= '0;
        end else begin
          if (ce)
            r_ptr <= (w_addr == AW'(DEPTH - 2)) ? '0 : w_addr + 1'b1;
          else if (w_clr)
            r_ptr <= '0;
          // The oldest buffered sample leaves the RAM as the new one replaces it.
          if (ce && !w_clr)
            r_q <= w_rd;
        end
      end
    end
  endgenerate

  assign q       = r_q;
  assign q_valid = r_valid;
  assign fill    = r_fill;

endmodule

// File: tb/tb_median_delay_line.sv
// Directed bench: three delay lines (DEPTH 4, 5, 1) share one stimulus stream;
// a per-instance queue of accepted samples supplies the expected q.
module tb_median_delay_line;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic [4:0] d;
  logic       clr;

  logic [4:0] q4, q5, q1;
  logic       v4, v5, v1;
  logic [2:0] f4, f5;
  logic [0:0] f1;

  int checks = 0;
  int errors = 0;

  logic [4:0] sb0[$];
  logic [4:0] sb1[$];
  logic [4:0] sb2[$];
  logic [4:0] exp_q[3];
  bit         known[3];
  int         exp_fill[3];

  always #5 clk = ~clk;

  median_delay_line #(.N(5), .DEPTH(4)) u_d4 (
    .clk(clk), .rst(rst),
`ifdef MEDIAN_DELAY_LINE_CLR_EN
    .clr(clr),
`endif
    .ce(ce), .d(d), .q(q4), .q_valid(v4), .fill(f4));

  median_delay_line #(.N(5), .DEPTH(5)) u_d5 (
    .clk(clk), .rst(rst),
`ifdef MEDIAN_DELAY_LINE_CLR_EN
    .clr(clr),
`endif
    .ce(ce), .d(d), .q(q5), .q_valid(v5), .fill(f5));

  median_delay_line #(.N(5), .DEPTH(1)) u_d1 (
    .clk(clk), .rst(rst),
`ifdef MEDIAN_DELAY_LINE_CLR_EN
    .clr(clr),
`endif
    .ce(ce), .d(d), .q(q1), .q_valid(v1), .fill(f1));

  function automatic int depth_of(input int i);
    case (i)
      0:       return 4;
      1:       return 5;
      default: return 1;
    endcase
  endfunction

  task automatic sb_clear(input int i);
    case (i)
      0:       sb0.delete();
      1:       sb1.delete();
      default: sb2.delete();
    endcase
  endtask

  task automatic sb_push(input int i, input logic [4:0] v);
    case (i)
      0:       sb0.push_back(v);
      1:       sb1.push_back(v);
      default: sb2.push_back(v);
    endcase
  endtask

  function automatic int sb_size(input int i);
    case (i)
      0:       return sb0.size();
      1:       return sb1.size();
      default: return sb2.size();
    endcase
  endfunction

  task automatic sb_pop(input int i, output logic [4:0] v);
    case (i)
      0:       v = sb0.pop_front();
      1:       v = sb1.pop_front();
      default: v = sb2.pop_front();
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the models, then compare every instance after the edge.
  task automatic step(input logic rst_v, input logic clr_v, input logic ce_v,
                      input logic [4:0] d_v, input string tag);
    logic [4:0] popped;
    rst = rst_v;
    clr = clr_v;
    ce  = ce_v;
    d   = d_v;
    for (int i = 0; i < 3; i++) begin
      if (rst_v) begin
        sb_clear(i);
        exp_fill[i] = 0;
        exp_q[i]    = '0;
        known[i]    = 1'b1;
      end else begin
        if (clr_v) begin
          sb_clear(i);
          exp_fill[i] = 0;
        end
        if (ce_v) begin
          sb_push(i, d_v);
          if (exp_fill[i] < depth_of(i)) exp_fill[i]++;
          if (sb_size(i) == depth_of(i)) begin
            sb_pop(i, popped);
            exp_q[i] = popped;
            known[i] = 1'b1;
          end else if (!clr_v) begin
            known[i] = 1'b0;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    check($sformatf("%s/d4.fill", tag), 32'(f4), 32'(exp_fill[0]));
    check($sformatf("%s/d4.q_valid", tag), 32'(v4), 32'(exp_fill[0] == 4));
    if (known[0]) check($sformatf("%s/d4.q", tag), 32'(q4), 32'(exp_q[0]));
    check($sformatf("%s/d5.fill", tag), 32'(f5), 32'(exp_fill[1]));
    check($sformatf("%s/d5.q_valid", tag), 32'(v5), 32'(exp_fill[1] == 5));
    if (known[1]) check($sformatf("%s/d5.q", tag), 32'(q5), 32'(exp_q[1]));
    check($sformatf("%s/d1.fill", tag), 32'(f1), 32'(exp_fill[2]));
    check($sformatf("%s/d1.q_valid", tag), 32'(v1), 32'(exp_fill[2] == 1));
    if (known[2]) check($sformatf("%s/d1.q", tag), 32'(q1), 32'(exp_q[2]));
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    ce  = 1'b0;
    d   = '0;

    step(1'b1, 1'b0, 1'b0, 5'd0, "reset");
    step(1'b1, 1'b0, 1'b1, 5'd9, "reset_ce");

    // Continuous fill and latency: d = 1..10.
    for (int k = 1; k <= 10; k++) step(1'b0, 1'b0, 1'b1, 5'(k), "fill");
    check("fill/d4.edge10_q", 32'(q4), 32'd7);

    // Gapped enable.
    step(1'b1, 1'b0, 1'b0, 5'd0, "rst_gap");
    step(1'b0, 1'b0, 1'b1, 5'd10, "gap");
    step(1'b0, 1'b0, 1'b0, 5'd99, "gap");
    step(1'b0, 1'b0, 1'b0, 5'd99, "gap");
    step(1'b0, 1'b0, 1'b1, 5'd11, "gap");
    step(1'b0, 1'b0, 1'b1, 5'd12, "gap");
    step(1'b0, 1'b0, 1'b0, 5'd99, "gap");
    step(1'b0, 1'b0, 1'b1, 5'd13, "gap");
    check("gap/d4.q_after_13", 32'(q4), 32'd10);

    // Long run exercising the non-power-of-two wrap of the DEPTH=5 instance.
    step(1'b1, 1'b0, 1'b0, 5'd0, "rst_wrap");
    for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 1'b1, 5'(k), "wrap");
    check("wrap/d5.q_after_19", 32'(q5), 32'd15);

    // Mid-run reset with a coincident sample that must be discarded.
    step(1'b1, 1'b0, 1'b0, 5'd0, "rst_mid");
    for (int k = 1; k <= 6; k++) step(1'b0, 1'b0, 1'b1, 5'(k), "mid");
    step(1'b1, 1'b0, 1'b1, 5'd31, "mid_rst");
    for (int k = 7; k <= 10; k++) step(1'b0, 1'b0, 1'b1, 5'(k), "mid_after");
    check("mid/d4.q_after_10", 32'(q4), 32'd7);

    // Single sample then idle: DEPTH=1 captures and holds.
    step(1'b1, 1'b0, 1'b0, 5'd0, "rst_d1");
    step(1'b0, 1'b0, 1'b1, 5'h1F, "d1");
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 5'd0, "d1_hold");
    check("d1/q_hold", 32'(q1), 32'h1F);

`ifdef MEDIAN_DELAY_LINE_CLR_EN
    // Restart mid-stream; q keeps its old value until the new run fills.
    step(1'b1, 1'b0, 1'b0, 5'd0, "rst_clr");
    for (int k = 1; k <= 6; k++) step(1'b0, 1'b0, 1'b1, 5'(k), "clr_pre");
    step(1'b0, 1'b1, 1'b1, 5'd20, "clr_edge");
    check("clr/d4.q_unchanged", 32'(q4), 32'd3);
    for (int k = 21; k <= 23; k++) step(1'b0, 1'b0, 1'b1, 5'(k), "clr_post");
    check("clr/d4.q_after_23", 32'(q4), 32'd20);
    step(1'b0, 1'b1, 1'b0, 5'd0, "clr_idle");
    step(1'b1, 1'b1, 1'b1, 5'd7, "clr_vs_rst");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
